// File: rtl/uart_fifo_ctrl.sv
// Synchronous FIFO controller for an external two-port, single-clock RAM
// with a one-cycle registered read on port B. Owns the pointers, occupancy
// flags, sticky error flags and the level interrupt.
module uart_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic                  i_clr_err,
    input  logic [ADDR_WIDTH:0]   i_thresh,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_underflow,
    output logic                  o_level_irq,
    output logic [ADDR_WIDTH-1:0] o_ram_addr_a,
    output logic [DATA_WIDTH-1:0] o_ram_data_a,
    output logic                  o_ram_wr_a,
    output logic [ADDR_WIDTH-1:0] o_ram_addr_b,
    output logic                  o_ram_wr_b,
    input  logic [DATA_WIDTH-1:0] i_ram_data_b
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic                rd_valid_q, rd_valid_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic full, empty;
    logic push_ok, pop_ok;
    logic ovf_evt, unf_evt;

    // Occupancy, acceptance and error-event decode.
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                  (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
        // A flush in the same cycle drops both requests.
        push_ok = !i_flush && i_wr_en && (!full || i_rd_en);
        pop_ok  = !i_flush && i_rd_en && !empty;
        ovf_evt = !i_flush && i_wr_en && full && !i_rd_en;
        unf_evt = !i_flush && i_rd_en && empty;
    end

    // Next-state for pointers, read-valid and sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            rd_valid_d = pop_ok;
        end

        // Set wins over clear when both happen in one cycle.
        if (i_clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (ovf_evt) begin
            overflow_d = 1'b1;
        end
        if (unf_evt) begin
            underflow_d = 1'b1;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Output and RAM port drive.
    always_comb begin
        o_full       = full;
        o_empty      = empty;
        o_count      = wr_ptr_q - rd_ptr_q;
        o_level_irq  = (i_thresh != '0) && (o_count >= i_thresh);
        o_rd_valid   = rd_valid_q;
        o_rd_data    = i_ram_data_b;
        o_overflow   = overflow_q;
        o_underflow  = underflow_q;
        o_ram_wr_a   = push_ok;
        o_ram_addr_a = wr_ptr_q[ADDR_WIDTH-1:0];
        o_ram_data_a = i_wr_data;
        o_ram_addr_b = rd_ptr_q[ADDR_WIDTH-1:0];
        o_ram_wr_b   = 1'b0;
    end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Self-checking bench for uart_fifo_ctrl: behavioural queue model plus a
// read-data scoreboard drained by an independent monitor.
module tb_uart_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst, flush, wr_en, rd_en, clr_err;
    logic [DW-1:0] wr_data;
    logic [AW:0]   thresh;
    logic [DW-1:0] rd_data;
    logic          rd_valid, full, empty, overflow, underflow, level_irq;
    logic [AW:0]   count;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_data_a, ram_q;
    logic          ram_wr_a, ram_wr_b;

    always #5 clk = ~clk;

    uart_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_wr_en(wr_en),
        .i_wr_data(wr_data), .i_rd_en(rd_en), .i_clr_err(clr_err),
        .i_thresh(thresh), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
        .o_full(full), .o_empty(empty), .o_count(count),
        .o_overflow(overflow), .o_underflow(underflow),
        .o_level_irq(level_irq), .o_ram_addr_a(ram_addr_a),
        .o_ram_data_a(ram_data_a), .o_ram_wr_a(ram_wr_a),
        .o_ram_addr_b(ram_addr_b), .o_ram_wr_b(ram_wr_b),
        .i_ram_data_b(ram_q)
    );

    // External RAM: port A write, port B registered read-before-write.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wr_a) mem[ram_addr_a] <= ram_data_a;
        ram_q <= mem[ram_addr_b];
    end

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    bit            m_valid = 1'b0;
    bit            m_ovf   = 1'b0;
    bit            m_unf   = 1'b0;
    int            m_thresh = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs after a falling edge, update the model,
    // then check registered state at the next falling edge.
    task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd,
                        input bit fl, input bit clr, input bit rs);
        bit m_full, m_empty, push, pop;
        rst = rs; flush = fl; wr_en = wr; wr_data = d; rd_en = rd;
        clr_err = clr; thresh = m_thresh[AW:0];
        #1;
        m_full  = (model_q.size() == DEPTH);
        m_empty = (model_q.size() == 0);
        push = !fl && wr && (!m_full || rd);
        pop  = !fl && rd && !m_empty;
        chk("ram_wr_a", ram_wr_a, push);
        chk("ram_wr_b", ram_wr_b, 0);
        if (rs) begin
            model_q.delete();
            m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else if (fl) begin
            model_q.delete();
            m_valid = 1'b0;
            if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
        end else begin
            if (pop) exp_q.push_back(model_q.pop_front());
            if (push) model_q.push_back(d);
            m_valid = pop;
            if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
            if (wr && m_full && !rd) m_ovf = 1'b1;
            if (rd && m_empty) m_unf = 1'b1;
        end
        @(negedge clk);
        chk("count", count, model_q.size());
        chk("full", full, model_q.size() == DEPTH);
        chk("empty", empty, model_q.size() == 0);
        chk("rd_valid", rd_valid, m_valid);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_unf);
        chk("level_irq", level_irq, (m_thresh != 0) && (model_q.size() >= m_thresh));
    endtask

    // Monitor: every presented read word must match the oldest expected one.
    logic [DW-1:0] mon_exp;
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", 1, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("rd_data", rd_data, mon_exp);
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        wr_data = '0; thresh = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        @(negedge clk);

        // Reset
        step(0, 8'h00, 0, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0, 1);

        // Fill, overflow, drain, underflow, clear
        for (int i = 0; i < DEPTH; i++) step(1, 8'h10 + i[7:0], 0, 0, 0, 0);
        step(1, 8'h18, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0, 0);
        step(0, 8'h00, 0, 0, 1, 0);

        // Wrap-around
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 5; i++) step(1, 8'h40 + 8'(r * 5 + i), 0, 0, 0, 0);
            for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 0, 0);
        end
        step(0, 8'h00, 0, 0, 0, 0);

        // Simultaneous push/pop while full, then drain
        for (int i = 0; i < DEPTH; i++) step(1, 8'hA0 + i[7:0], 0, 0, 0, 0);
        step(1, 8'hB0, 1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0, 0);

        // Simultaneous push/pop while empty
        step(1, 8'hC5, 1, 0, 0, 0);
        step(0, 8'h00, 1, 0, 1, 0);
        step(0, 8'h00, 0, 0, 0, 0);

        // Level interrupt and flush priority, with a sticky error standing
        step(0, 8'h00, 1, 0, 0, 0);
        m_thresh = 4;
        for (int i = 0; i < 4; i++) step(1, 8'h60 + i[7:0], 0, 0, 0, 0);
        step(1, 8'h99, 0, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0, 0);

        // Randomized traffic with occasional flush, clear and reset
        for (int n = 0; n < 600; n++) begin
            if (n % 60 == 0) m_thresh = $urandom_range(0, DEPTH);
            step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6,
                 $urandom_range(0, 199) == 0);
        end
        step(0, 8'h00, 0, 0, 0, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
